// File: rtl/tron_pkg.sv
// Shared encodings for the Tron match sequencer: FSM states, winner codes, BCD digit type.
// Pure declarations; no timing or flow-control behaviour.
package tron_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'b000,
      ST_COUNTDOWN  = 3'b001,
      ST_PLAY       = 3'b010,
      ST_ROUND_OVER = 3'b011,
      ST_MATCH_OVER = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

endpackage

// File: rtl/tron_tick_gen.sv
// Game-step tick: Tick is high while the free-running count sits at TICK_DIV-1.
// Count is zeroed by Clr or while En is low; no backpressure.
module tron_tick_gen #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Clr,
   input  logic En,
   output logic Tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] tick_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tick_cnt <= '0;
      end else if (Clr || !En) begin
         tick_cnt <= '0;
      end else if (tick_cnt == CNT_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   // Not gated by Clr: Clr is derived from this tick, gating would form a loop.
   assign Tick = En && (tick_cnt == CNT_LAST);

endmodule

// File: rtl/tron_match_ctrl.sv
// Tron match/round sequencer: countdown, move pacing, crash scoring, match winner.
// All outputs registered (1-cycle from inputs); Start/crash are single-cycle events, no backpressure.
module tron_match_ctrl
   import tron_pkg::*;
#(
   parameter int TICK_DIV        = 5_000_000,
   parameter int COUNTDOWN_STEPS = 3,
   parameter int WIN_SCORE       = 5,
   parameter int HOLD_TICKS      = 40
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Crash_P1,
   input  logic       Crash_P2,
   output logic       Move_En,
   output logic       Arena_Clr,
   output logic [3:0] P1_Score,
   output logic [3:0] P2_Score,
   output logic [3:0] Countdown,
   output logic [1:0] Winner,
   output logic [2:0] State
);

   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("TICK_DIV must be at least 2");
   end
   if (COUNTDOWN_STEPS < 1 || COUNTDOWN_STEPS > 9) begin : g_bad_countdown
      $error("COUNTDOWN_STEPS must be 1..9");
   end
   if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win_score
      $error("WIN_SCORE must be 1..9");
   end
   if (HOLD_TICKS < 1) begin : g_bad_hold
      $error("HOLD_TICKS must be at least 1");
   end

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam digit_t CD_LOAD = digit_t'(COUNTDOWN_STEPS);
   localparam digit_t WIN_DIG = digit_t'(WIN_SCORE);

   state_t            state_q, state_d;
   winner_t           winner_q, winner_d;
   digit_t            p1_q, p1_d, p2_q, p2_d, cd_q, cd_d;
   digit_t            p1_inc, p2_inc;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              move_en_q, move_en_d;
   logic              arena_clr_q, to_countdown;
   logic              tick, tick_en, tick_clr;

   assign p1_inc   = p1_q + digit_t'(1);
   assign p2_inc   = p2_q + digit_t'(1);
   assign tick_en  = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY) ||
                     (state_q == ST_ROUND_OVER);
   assign tick_clr = (state_d != state_q);

   tron_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .Clk   (Clk),
      .Reset (Reset),
      .Clr   (tick_clr),
      .En    (tick_en),
      .Tick  (tick)
   );

   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      p1_d         = p1_q;
      p2_d         = p2_q;
      cd_d         = cd_q;
      hold_d       = hold_q;
      move_en_d    = 1'b0;
      to_countdown = 1'b0;

      case (state_q)
         ST_IDLE: begin
            p1_d     = '0;
            p2_d     = '0;
            winner_d = WIN_NONE;
            if (Start) begin
               state_d      = ST_COUNTDOWN;
               to_countdown = 1'b1;
            end
         end
         ST_COUNTDOWN: begin
            if (tick) begin
               if (cd_q == digit_t'(1)) begin
                  state_d = ST_PLAY;
                  cd_d    = '0;
               end else begin
                  cd_d = cd_q - digit_t'(1);
               end
            end
         end
         ST_PLAY: begin
            // A crash takes priority over a coincident tick: no step is issued.
            if (Crash_P1 && Crash_P2) begin
               winner_d = WIN_DRAW;
               state_d  = ST_ROUND_OVER;
            end else if (Crash_P1) begin
               p2_d     = p2_inc;
               winner_d = WIN_P2;
               state_d  = (p2_inc == WIN_DIG) ? ST_MATCH_OVER : ST_ROUND_OVER;
            end else if (Crash_P2) begin
               p1_d     = p1_inc;
               winner_d = WIN_P1;
               state_d  = (p1_inc == WIN_DIG) ? ST_MATCH_OVER : ST_ROUND_OVER;
            end else begin
               move_en_d = tick;
            end
         end
         ST_ROUND_OVER: begin
            if (tick) begin
               hold_d = hold_q + HOLD_W'(1);
            end
            if (Start || (tick && hold_q == HOLD_LAST)) begin
               state_d      = ST_COUNTDOWN;
               to_countdown = 1'b1;
               winner_d     = WIN_NONE;
            end
         end
         ST_MATCH_OVER: begin
            if (Start) begin
               state_d  = ST_IDLE;
               p1_d     = '0;
               p2_d     = '0;
               winner_d = WIN_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (to_countdown) begin
         cd_d = CD_LOAD;
      end
      if (state_d != state_q) begin
         hold_d = '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         winner_q    <= WIN_NONE;
         p1_q        <= '0;
         p2_q        <= '0;
         cd_q        <= '0;
         hold_q      <= '0;
         move_en_q   <= 1'b0;
         arena_clr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         cd_q        <= cd_d;
         hold_q      <= hold_d;
         move_en_q   <= move_en_d;
         arena_clr_q <= to_countdown;
      end
   end

   assign Move_En   = move_en_q;
   assign Arena_Clr = arena_clr_q;
   assign P1_Score  = p1_q;
   assign P2_Score  = p2_q;
   assign Countdown = cd_q;
   assign Winner    = winner_q;
   assign State     = state_q;

endmodule

// File: tb/tb_tron_match_ctrl.sv
// Scoreboard bench for tron_match_ctrl: stimulus queues hand-timed output events,
// a monitor pops and compares each visible change or pulse, plus async-reset probes.
module tb_tron_match_ctrl;

   localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_RO = 3, S_MO = 4;
   localparam int W_NONE = 0, W_P1 = 1, W_P2 = 2, W_DRAW = 3;

   typedef struct {
      int cyc;
      int st;
      int cd;
      int p1;
      int p2;
      int win;
      int mv;
      int clr;
   } ev_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Crash_P1;
   logic       Crash_P2;
   logic       Move_En;
   logic       Arena_Clr;
   logic [3:0] P1_Score;
   logic [3:0] P2_Score;
   logic [3:0] Countdown;
   logic [1:0] Winner;
   logic [2:0] State;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  probe_cnt = 0;
   bit  fin_req = 1'b0;
   ev_t exp_q[$];

   tron_match_ctrl #(
      .TICK_DIV        (4),
      .COUNTDOWN_STEPS (3),
      .WIN_SCORE       (2),
      .HOLD_TICKS      (2)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Crash_P1  (Crash_P1),
      .Crash_P2  (Crash_P2),
      .Move_En   (Move_En),
      .Arena_Clr (Arena_Clr),
      .P1_Score  (P1_Score),
      .P2_Score  (P2_Score),
      .Countdown (Countdown),
      .Winner    (Winner),
      .State     (State)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic ex(input int c, input int st, input int cd, input int p1, input int p2,
                     input int win, input int mv, input int clr);
      ev_t e;
      e.cyc = c; e.st = st; e.cd = cd; e.p1 = p1; e.p2 = p2;
      e.win = win; e.mv = mv; e.clr = clr;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
      #1;
   endtask

   initial begin : monitor
      ev_t         e;
      logic [16:0] cur;
      logic [16:0] prev;
      int          probe_seen;
      prev       = '0;
      probe_seen = 0;
      forever begin
         @(negedge Clk or probe_cnt or fin_req);
         cur = {State, Countdown, P1_Score, P2_Score, Winner};
         if (probe_cnt != probe_seen) begin
            probe_seen = probe_cnt;
            #1;
            checks++;
            if ({State, Countdown, P1_Score, P2_Score, Winner, Move_En, Arena_Clr} !== 19'd0) begin
               errors++;
               $display("FAIL reset_probe %0d: got st=%b cd=%0d p1=%0d p2=%0d w=%b mv=%b clr=%b, want all 0",
                        probe_seen, State, Countdown, P1_Score, P2_Score, Winner, Move_En, Arena_Clr);
            end
         end else if (fin_req) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL missing_events: %0d expected events never seen, first due at cycle %0d",
                        exp_q.size(), exp_q[0].cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end else if (cyc > 3000) begin
            errors++;
            $display("FAIL timeout: cycle %0d, stimulus never finished", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end else if (Reset) begin
            prev = cur;
         end else if (Move_En || Arena_Clr || cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event @%0d: st=%0d cd=%0d p1=%0d p2=%0d w=%0d mv=%b clr=%b",
                        cyc, State, Countdown, P1_Score, P2_Score, Winner, Move_En, Arena_Clr);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.cyc || int'(State) != e.st || int'(Countdown) != e.cd ||
                   int'(P1_Score) != e.p1 || int'(P2_Score) != e.p2 || int'(Winner) != e.win ||
                   int'(Move_En) != e.mv || int'(Arena_Clr) != e.clr) begin
                  errors++;
                  $display("FAIL event: got cyc=%0d st=%0d cd=%0d p1=%0d p2=%0d w=%0d mv=%0d clr=%0d; want cyc=%0d st=%0d cd=%0d p1=%0d p2=%0d w=%0d mv=%0d clr=%0d",
                           cyc, State, Countdown, P1_Score, P2_Score, Winner, Move_En, Arena_Clr,
                           e.cyc, e.st, e.cd, e.p1, e.p2, e.win, e.mv, e.clr);
               end
            end
            prev = cur;
         end else begin
            prev = cur;
         end
      end
   end

   initial begin : stim
      int j, s, t;
      Start = 1'b0; Crash_P1 = 1'b0; Crash_P2 = 1'b0; Reset = 1'b1;
      step(2); #2; probe_cnt++;
      step(1); Reset = 1'b0;
      step(2);

      // Round 1: countdown, three steps, P1 crashes, hold expires on its own.
      j = cyc; Start = 1'b1;
      ex(j+1,  S_CD,   3, 0, 0, W_NONE, 0, 1);
      ex(j+5,  S_CD,   2, 0, 0, W_NONE, 0, 0);
      ex(j+9,  S_CD,   1, 0, 0, W_NONE, 0, 0);
      ex(j+13, S_PLAY, 0, 0, 0, W_NONE, 0, 0);
      ex(j+17, S_PLAY, 0, 0, 0, W_NONE, 1, 0);
      ex(j+21, S_PLAY, 0, 0, 0, W_NONE, 1, 0);
      ex(j+25, S_PLAY, 0, 0, 0, W_NONE, 1, 0);
      ex(j+28, S_RO,   0, 0, 1, W_P2,   0, 0);
      ex(j+36, S_CD,   3, 0, 1, W_NONE, 0, 1);
      ex(j+40, S_CD,   2, 0, 1, W_NONE, 0, 0);
      ex(j+44, S_CD,   1, 0, 1, W_NONE, 0, 0);
      ex(j+48, S_PLAY, 0, 0, 1, W_NONE, 0, 0);
      step(1); Start = 1'b0;
      step(2); Start = 1'b1; Crash_P1 = 1'b1;
      step(1); Start = 1'b0; Crash_P1 = 1'b0;
      step(23); Crash_P1 = 1'b1;
      step(1); Crash_P1 = 1'b0;
      step(2); Crash_P2 = 1'b1;
      step(1); Crash_P2 = 1'b0;

      // Round 2: double crash on a tick cycle, then early Start out of the hold.
      step(20); Crash_P1 = 1'b1; Crash_P2 = 1'b1;
      ex(j+52, S_RO, 0, 0, 1, W_DRAW, 0, 0);
      step(1); Crash_P1 = 1'b0; Crash_P2 = 1'b0;
      step(1); Start = 1'b1;
      ex(j+54, S_CD,   3, 0, 1, W_NONE, 0, 1);
      ex(j+58, S_CD,   2, 0, 1, W_NONE, 0, 0);
      ex(j+62, S_CD,   1, 0, 1, W_NONE, 0, 0);
      ex(j+66, S_PLAY, 0, 0, 1, W_NONE, 0, 0);
      ex(j+70, S_PLAY, 0, 0, 1, W_NONE, 1, 0);
      step(1); Start = 1'b0;

      // Round 3: P2 crashes; Start lands on the hold-expiry tick.
      step(17); Crash_P2 = 1'b1;
      ex(j+72, S_RO, 0, 1, 1, W_P1, 0, 0);
      step(1); Crash_P2 = 1'b0;
      step(7); Start = 1'b1;
      ex(j+80, S_CD,   3, 1, 1, W_NONE, 0, 1);
      ex(j+84, S_CD,   2, 1, 1, W_NONE, 0, 0);
      ex(j+88, S_CD,   1, 1, 1, W_NONE, 0, 0);
      ex(j+92, S_PLAY, 0, 1, 1, W_NONE, 0, 0);
      step(1); Start = 1'b0;

      // Round 4: Start ignored in play, P2 crash wins the match, later crashes ignored.
      step(13); Start = 1'b1;
      step(1); Start = 1'b0; Crash_P2 = 1'b1;
      ex(j+95, S_MO, 0, 2, 1, W_P1, 0, 0);
      step(1); Crash_P2 = 1'b0;
      step(2); Crash_P1 = 1'b1; Crash_P2 = 1'b1;
      step(3); Crash_P1 = 1'b0; Crash_P2 = 1'b0;
      step(2); Start = 1'b1;
      ex(j+103, S_IDLE, 0, 0, 0, W_NONE, 0, 0);
      step(1); Start = 1'b0;

      // Async reset mid-play on a tick cycle, then a clean restart.
      step(2); s = cyc; Start = 1'b1;
      ex(s+1,  S_CD,   3, 0, 0, W_NONE, 0, 1);
      ex(s+5,  S_CD,   2, 0, 0, W_NONE, 0, 0);
      ex(s+9,  S_CD,   1, 0, 0, W_NONE, 0, 0);
      ex(s+13, S_PLAY, 0, 0, 0, W_NONE, 0, 0);
      ex(s+17, S_PLAY, 0, 0, 0, W_NONE, 1, 0);
      step(1); Start = 1'b0;
      step(19); #2; Reset = 1'b1; probe_cnt++;
      step(3); Reset = 1'b0;
      step(2); t = cyc; Start = 1'b1;
      ex(t+1,  S_CD,   3, 0, 0, W_NONE, 0, 1);
      ex(t+5,  S_CD,   2, 0, 0, W_NONE, 0, 0);
      ex(t+9,  S_CD,   1, 0, 0, W_NONE, 0, 0);
      ex(t+13, S_PLAY, 0, 0, 0, W_NONE, 0, 0);
      ex(t+17, S_PLAY, 0, 0, 0, W_NONE, 1, 0);
      step(1); Start = 1'b0;
      step(17); fin_req = 1'b1;
   end

endmodule
